ack_responder: RTL and testbench

//  Receive-side ack engine for inter-device links. Returns a hop-level ack for every accepted non-ack rx flit.

---
 rtl/ack_responder_pkg.sv | 46 ++++
 rtl/ack_responder_if.sv | 16 +
 rtl/ack_responder_queue.sv | 56 +++++
 rtl/ack_responder.sv | 162 ++++++++++++++++
 tb/tb_ack_responder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ack_responder_pkg.sv
// ack_responder_pkg
//   Shared types for the inter-device ack responder: node/flit identifiers,
//   the link flit layout, the duplicate-filter table entry and the helper
//   that builds a hop-level ack flit from a received flit.
package ack_responder_pkg;

  localparam int NODE_ID_W = 4;
  localparam int FLIT_ID_W = 8;
  localparam int PAYLOAD_W = 32;

  // Age counters are sized for the default duplicate window. A larger
  // window needs this width raised so the expiry compare can be reached.
  localparam int DUP_WINDOW_DEFAULT = 400;
  localparam int DUP_AGE_W          = $clog2(DUP_WINDOW_DEFAULT + 1);

  typedef logic [NODE_ID_W-1:0] node_id_t;
  typedef logic [FLIT_ID_W-1:0] flit_id_t;

  typedef struct packed {
    logic                 is_ack;
    node_id_t             src_id;
    node_id_t             dst_id;
    flit_id_t             flit_id;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef struct packed {
    logic                 valid;
    node_id_t             node_id;
    flit_id_t             flit_id;
    logic [DUP_AGE_W-1:0] age;
  } dup_entry_t;

  // Ack goes back to the sender of rx and carries the same flit_id so the
  // peer can retire the matching entry in its resend buffer.
  function automatic flit_t make_ack_flit(input flit_t rx, input node_id_t self_id);
    flit_t ack;
    ack         = '0;
    ack.is_ack  = 1'b1;
    ack.src_id  = self_id;
    ack.dst_id  = rx.src_id;
    ack.flit_id = rx.flit_id;
    return ack;
  endfunction

endpackage

// File: rtl/ack_responder_if.sv
// ack_responder_if
//   Valid/ready flit channel used for the rx input, the local router output
//   and the ack tx output of the ack responder.
//   flit  : flit_t  payload, driven by the master
//   valid : 1       flit present, driven by the master
//   ready : 1       flit accepted when valid&ready, driven by the slave
interface ack_responder_if;
  import ack_responder_pkg::*;

  flit_t flit;
  logic  valid;
  logic  ready;

  modport master (output flit, output valid, input  ready);
  modport slave  (input  flit, input  valid, output ready);
endinterface

// File: rtl/ack_responder_queue.sv
// ack_responder_queue
//   Small synchronous FIFO holding outgoing ack flits.
//   nocclk    in   clock
//   rst_n     in   async active-low reset, empties the queue
//   push      in   write push_data when not full
//   push_data in   entry to enqueue
//   full      out  no free entry
//   pop       in   discard head entry when not empty
//   pop_data  out  head entry, '0 while empty
//   empty     out  no entry stored
module ack_responder_queue #(
  parameter int NUM_ENTRIES = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  nocclk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);

  logic [DATA_WIDTH-1:0] mem [NUM_ENTRIES];
  // One extra pointer bit separates the full and empty cases.
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge nocclk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/ack_responder.sv
// ack_responder
//   Receive-side ack engine for an inter-device link. Every accepted non-ack
//   flit is answered with a hop-level ack. Resends of a flit already seen
//   from the same source are dropped but still re-acked. Incoming ack flits
//   are forwarded to the local waiting-ack tracker.
//   nocclk                 in   clock
//   rst_n                  in   async active-low reset
//   this_node_id           in   id of this device, src_id of generated acks
//   interdevice_rx         slv  received flits from the link
//   local_rx               mst  non-duplicate data flits to the local router
//   ack_tx                 mst  generated ack flits to the tx arbiter
//   waiting_ack_flit       out  received ack flit, '0 while not valid
//   waiting_ack_flit_valid out  one-cycle strobe, no backpressure
module ack_responder
  import ack_responder_pkg::*;
#(
  parameter int ACK_QUEUE_DEPTH   = 4,
  parameter int DUP_TABLE_ENTRIES = 8,
  parameter int DUP_WINDOW        = DUP_WINDOW_DEFAULT
) (
  input  logic                   nocclk,
  input  logic                   rst_n,
  input  node_id_t               this_node_id,
  ack_responder_if.slave         interdevice_rx,
  ack_responder_if.master        local_rx,
  ack_responder_if.master        ack_tx,
  output flit_t                  waiting_ack_flit,
  output logic                   waiting_ack_flit_valid
);

  localparam int                   IDX_W     = $clog2(DUP_TABLE_ENTRIES);
  localparam logic [DUP_AGE_W-1:0] AGE_LIMIT = DUP_AGE_W'(DUP_WINDOW);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DUP_TABLE_ENTRIES - 1);

  function automatic logic [DUP_AGE_W-1:0] sat_inc(input logic [DUP_AGE_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  dup_entry_t         dup_table [DUP_TABLE_ENTRIES];
  logic [IDX_W-1:0]   repl_ptr;

  flit_t              rx_flit;
  logic               rx_valid;
  logic               is_ack;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               is_dup;
  logic               is_new;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               rx_ready;
  logic               rx_fire;
  logic               new_fire;
  logic               dup_fire;
  logic               upd_en;
  logic [IDX_W-1:0]   upd_idx;
  logic               ack_full;
  logic               ack_empty;
  logic [$bits(flit_t)-1:0] ack_head;

  assign rx_flit  = interdevice_rx.flit;
  assign rx_valid = interdevice_rx.valid;
  assign is_ack   = rx_flit.is_ack;

  // An unknown src_id makes the match condition X, which the if treats as
  // false, so such a flit falls through as a miss.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DUP_TABLE_ENTRIES; i++) begin
      if (dup_table[i].valid && (dup_table[i].node_id == rx_flit.src_id)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign is_dup = !is_ack && hit && (dup_table[hit_idx].flit_id == rx_flit.flit_id);
  assign is_new = !is_ack && !is_dup;

  // Scanning downward leaves the lowest invalid index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DUP_TABLE_ENTRIES - 1; i >= 0; i--) begin
      if (!dup_table[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Ack flits never need queue space; data flits need room for their ack,
  // and new data also needs the local router to take it.
  always_comb begin
    rx_ready = 1'b0;
    if (rst_n) begin
      if (is_ack)      rx_ready = 1'b1;
      else if (is_dup) rx_ready = !ack_full;
      else             rx_ready = !ack_full && local_rx.ready;
    end
  end

  assign interdevice_rx.ready = rx_ready;
  assign rx_fire  = rx_valid && rx_ready;
  assign new_fire = rx_fire && is_new;
  assign dup_fire = rx_fire && is_dup;

  assign local_rx.valid = rst_n && rx_valid && is_new && !ack_full;
  assign local_rx.flit  = local_rx.valid ? rx_flit : '0;

  assign waiting_ack_flit_valid = rst_n && rx_valid && is_ack;
  assign waiting_ack_flit       = waiting_ack_flit_valid ? rx_flit : '0;

  ack_responder_queue #(
    .NUM_ENTRIES (ACK_QUEUE_DEPTH),
    .DATA_WIDTH  ($bits(flit_t))
  ) u_ack_queue (
    .nocclk    (nocclk),
    .rst_n     (rst_n),
    .push      (new_fire || dup_fire),
    .push_data (make_ack_flit(rx_flit, this_node_id)),
    .full      (ack_full),
    .pop       (ack_tx.ready),
    .pop_data  (ack_head),
    .empty     (ack_empty)
  );

  assign ack_tx.valid = !ack_empty;
  assign ack_tx.flit  = flit_t'(ack_head);

  // Entry written this cycle: the hit entry for both new and dup accepts,
  // otherwise the lowest free slot, otherwise the round-robin victim.
  assign upd_en  = new_fire || dup_fire;
  assign upd_idx = hit ? hit_idx : (free_found ? free_idx : repl_ptr);

  // dup table register stage
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DUP_TABLE_ENTRIES; i++) dup_table[i] <= '0;
      repl_ptr <= '0;
    end else begin
      for (int i = 0; i < DUP_TABLE_ENTRIES; i++) begin
        if (upd_en && (upd_idx == IDX_W'(i))) begin
          dup_table[i].valid <= 1'b1;
          dup_table[i].age   <= '0;
          if (new_fire) begin
            dup_table[i].node_id <= rx_flit.src_id;
            dup_table[i].flit_id <= rx_flit.flit_id;
          end
        end else if (dup_table[i].valid) begin
          dup_table[i].age <= sat_inc(dup_table[i].age);
          if (dup_table[i].age == AGE_LIMIT) dup_table[i].valid <= 1'b0;
        end
      end
      if (new_fire && !hit && !free_found) begin
        repl_ptr <= (repl_ptr == LAST_IDX) ? '0 : repl_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ack_responder.sv
module tb_ack_responder;
  import ack_responder_pkg::*;

  localparam int       DW   = 400;
  localparam node_id_t NODE = 4'hA;

  logic     nocclk = 1'b0;
  logic     rst_n  = 1'b1;
  node_id_t this_node_id;
  flit_t    wa_flit;
  logic     wa_valid;

  int n_assert = 0;
  int n_fail   = 0;

  ack_responder_if rx_if ();
  ack_responder_if loc_if ();
  ack_responder_if ack_if ();

  ack_responder #(
    .ACK_QUEUE_DEPTH   (4),
    .DUP_TABLE_ENTRIES (8),
    .DUP_WINDOW        (DW)
  ) dut (
    .nocclk                 (nocclk),
    .rst_n                  (rst_n),
    .this_node_id           (this_node_id),
    .interdevice_rx         (rx_if),
    .local_rx               (loc_if),
    .ack_tx                 (ack_if),
    .waiting_ack_flit       (wa_flit),
    .waiting_ack_flit_valid (wa_valid)
  );

  always #5 nocclk = ~nocclk;

  function automatic flit_t dflit(input node_id_t s, input flit_id_t id);
    flit_t f;
    f         = '0;
    f.src_id  = s;
    f.dst_id  = NODE;
    f.flit_id = id;
    f.payload = {24'hC0FFEE, id};
    return f;
  endfunction

  function automatic flit_t aflit(input node_id_t s, input flit_id_t id);
    flit_t f;
    f         = '0;
    f.is_ack  = 1'b1;
    f.src_id  = NODE;
    f.dst_id  = s;
    f.flit_id = id;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge nocclk);
    #1;
  endtask

  task automatic present(input flit_t f);
    rx_if.flit  = f;
    rx_if.valid = 1'b1;
    #1;
  endtask

  task automatic idle();
    rx_if.valid = 1'b0;
    rx_if.flit  = '0;
    #1;
  endtask

  task automatic pulse_reset();
    rx_if.valid = 1'b0;
    rx_if.flit  = '0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
  endtask

  flit_t peer_ack;

  initial begin
    this_node_id = NODE;
    rx_if.valid  = 1'b0;
    rx_if.flit   = '0;
    loc_if.ready = 1'b1;
    ack_if.ready = 1'b1;
    peer_ack         = '0;
    peer_ack.is_ack  = 1'b1;
    peer_ack.src_id  = 4'd3;
    peer_ack.dst_id  = NODE;
    peer_ack.flit_id = 8'h77;

    // Reset state, with an ack flit offered on rx
    #1 rst_n = 1'b0;
    rx_if.flit  = peer_ack;
    rx_if.valid = 1'b1;
    #2;
    chk("rst_ack_valid",   64'(ack_if.valid), 64'd0);
    chk("rst_local_valid", 64'(loc_if.valid), 64'd0);
    chk("rst_wa_valid",    64'(wa_valid),     64'd0);
    chk("rst_rx_ready",    64'(rx_if.ready),  64'd0);
    chk("rst_ack_flit",    64'(ack_if.flit),  64'd0);
    chk("rst_local_flit",  64'(loc_if.flit),  64'd0);
    chk("rst_wa_flit",     64'(wa_flit),      64'd0);
    rx_if.valid = 1'b0;
    rx_if.flit  = '0;
    #1 rst_n = 1'b1;
    step();

    // New flit src=2 id=5
    present(dflit(2, 5));
    chk("t2_rx_ready",     64'(rx_if.ready),  64'd1);
    chk("t2_local_valid",  64'(loc_if.valid), 64'd1);
    chk("t2_local_flit",   64'(loc_if.flit),  64'(dflit(2, 5)));
    chk("t2_ack_not_yet",  64'(ack_if.valid), 64'd0);
    step(); idle();
    chk("t2_ack_valid",    64'(ack_if.valid), 64'd1);
    chk("t2_ack_flit",     64'(ack_if.flit),  64'(aflit(2, 5)));
    chk("t2_local_idle",   64'(loc_if.valid), 64'd0);
    chk("t2_local_flit0",  64'(loc_if.flit),  64'd0);
    step();
    chk("t2_ack_drained",  64'(ack_if.valid), 64'd0);

    // Resend of src=2 id=5 is a duplicate, still acked
    present(dflit(2, 5));
    chk("t3_dup_rx_ready",    64'(rx_if.ready),  64'd1);
    chk("t3_dup_local_valid", 64'(loc_if.valid), 64'd0);
    step(); idle();
    chk("t3_dup_ack_valid",   64'(ack_if.valid), 64'd1);
    chk("t3_dup_ack_flit",    64'(ack_if.flit),  64'(aflit(2, 5)));
    step();
    repeat (DW - 1) step();
    // Entry age is exactly DW here: still a duplicate, and the touch wins
    present(dflit(2, 5));
    chk("t3_edge_local_valid", 64'(loc_if.valid), 64'd0);
    chk("t3_edge_rx_ready",    64'(rx_if.ready),  64'd1);
    step(); idle();
    chk("t3_edge_ack_valid",   64'(ack_if.valid), 64'd1);
    step();
    repeat (DW) step();
    present(dflit(2, 5));
    chk("t3_expired_local_valid", 64'(loc_if.valid), 64'd1);
    step(); idle();
    chk("t3_expired_ack_flit",    64'(ack_if.flit),  64'(aflit(2, 5)));
    step();

    // Mid-stream reset with three acks queued
    ack_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(dflit(node_id_t'(4 + i), flit_id_t'(8'h40 + i)));
      chk("t1_fill_rx_ready", 64'(rx_if.ready), 64'd1);
      step();
    end
    idle();
    chk("t1_queued_valid", 64'(ack_if.valid), 64'd1);
    chk("t1_queued_head",  64'(ack_if.flit),  64'(aflit(4, 8'h40)));
    rst_n = 1'b0;
    #1;
    chk("t1_rst_ack_valid", 64'(ack_if.valid), 64'd0);
    chk("t1_rst_ack_flit",  64'(ack_if.flit),  64'd0);
    rst_n = 1'b1;
    ack_if.ready = 1'b1;
    present(dflit(4, 8'h40));
    chk("t1_after_rst_new",    64'(loc_if.valid), 64'd1);
    chk("t1_after_rst_ackq",   64'(ack_if.valid), 64'd0);
    step(); idle();
    chk("t1_after_rst_ack",    64'(ack_if.flit),  64'(aflit(4, 8'h40)));
    step();

    // Full ack queue blocks the fifth data flit
    pulse_reset();
    ack_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(dflit(node_id_t'(1 + i), flit_id_t'(8'h10 + i)));
      chk("t4_fill_rx_ready", 64'(rx_if.ready), 64'd1);
      step();
    end
    present(dflit(5, 8'h14));
    chk("t4_full_rx_ready",    64'(rx_if.ready),  64'd0);
    chk("t4_full_local_valid", 64'(loc_if.valid), 64'd0);
    chk("t4_head1",            64'(ack_if.flit),  64'(aflit(1, 8'h10)));
    ack_if.ready = 1'b1;
    #1;
    chk("t4_no_bypass",        64'(rx_if.ready),  64'd0);
    step();
    chk("t4_space_rx_ready",   64'(rx_if.ready),  64'd1);
    chk("t4_space_local",      64'(loc_if.valid), 64'd1);
    chk("t4_head2",            64'(ack_if.flit),  64'(aflit(2, 8'h11)));
    step(); idle();
    chk("t4_head3",            64'(ack_if.flit),  64'(aflit(3, 8'h12)));
    step();
    chk("t4_head4",            64'(ack_if.flit),  64'(aflit(4, 8'h13)));
    step();
    chk("t4_head5",            64'(ack_if.flit),  64'(aflit(5, 8'h14)));
    step();
    chk("t4_drained",          64'(ack_if.valid), 64'd0);

    // Ack flit accepted with full queue and local router stalled
    pulse_reset();
    ack_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(dflit(node_id_t'(6 + i), flit_id_t'(8'h60 + i)));
      chk("t5_fill_rx_ready", 64'(rx_if.ready), 64'd1);
      step();
    end
    idle();
    loc_if.ready = 1'b0;
    present(peer_ack);
    chk("t5_rx_ready",     64'(rx_if.ready),  64'd1);
    chk("t5_wa_valid",     64'(wa_valid),     64'd1);
    chk("t5_wa_flit",      64'(wa_flit),      64'(peer_ack));
    chk("t5_local_valid",  64'(loc_if.valid), 64'd0);
    step(); idle();
    chk("t5_wa_pulse_end", 64'(wa_valid),     64'd0);
    chk("t5_wa_flit0",     64'(wa_flit),      64'd0);
    chk("t5_head",         64'(ack_if.flit),  64'(aflit(6, 8'h60)));
    loc_if.ready = 1'b1;
    ack_if.ready = 1'b1;
    repeat (4) step();
    chk("t5_no_extra_ack", 64'(ack_if.valid), 64'd0);

    // Table replacement once all entries are in use
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      present(dflit(node_id_t'(i), flit_id_t'(8'h20 + i)));
      chk("t6_fill_new", 64'(loc_if.valid), 64'd1);
      step();
    end
    present(dflit(9, 8'h29));
    chk("t6_src9_new", 64'(loc_if.valid), 64'd1);
    step();
    present(dflit(0, 8'h20));
    chk("t6_src0_new", 64'(loc_if.valid), 64'd1);
    step();
    present(dflit(1, 8'h21));
    chk("t6_src1_new", 64'(loc_if.valid), 64'd1);
    step();
    present(dflit(3, 8'h23));
    chk("t6_src3_dup", 64'(loc_if.valid), 64'd0);
    chk("t6_src3_rdy", 64'(rx_if.ready),  64'd1);
    step(); idle();
    chk("t6_src3_ack", 64'(ack_if.flit),  64'(aflit(3, 8'h23)));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
